life_seeder: RTL
================

// Module: life_seeder
// PURPOSE
//  Fills the life frame buffer in external SRAM with an initial generation.
//  Data is pseudo-random (32-bit LFSR) at a selectable density, or all zero (clear).
//  Runs in the clk_pixel domain and issues byte writes to the SRAM controller over a
//  req/ack port. The controller grants them in write slots while the life engine is
//  paused (control[7]=0).
//  Upstream of the life engine: the engine's first generation is whatever this block writes.
// PARAMETERS
//  ADDR_WIDTH   19             SRAM byte address width
//  ROW_BYTES    240            bytes per row (1920 px / 8)
//  NUM_ROWS     1080           rows per frame
//  BORDER_DEAD  1              1: force the outermost ring of cells to dead
//  LFSR_POLY    32'h80200003   Galois feedback mask (x^32+x^22+x^2+x+1)
// PORTS
//  clk_pixel  in   1   pixel/system clock (150 MHz)
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   single-cycle pulse: begin a fill; ignored while busy
//  abort      in   1   level/pulse: cancel the fill in progress
//  mode       in   2   00 clear, 01 50%, 10 25%, 11 12.5% density; sampled on start
//  seed       in   32  LFSR seed, sampled on start; 0 is replaced by 32'h1
//  wr_req     out  1   write request; addr/data stable while high
//  wr_addr    out  19  SRAM byte address
//  wr_data    out  8   byte to write; bit7 = leftmost pixel
//  wr_ack     in   1   one-cycle pulse from the controller when the byte is committed
//  busy       out  1   high from the cycle after start until done/abort
//  done       out  1   one-cycle pulse after the last byte is acked
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; lfsr=1; col=row=0.
//  FSM: IDLE --start--> FILL --ack of last byte--> IDLE (done=1 for 1 cycle).
//       FILL --abort--> IDLE (no done). abort has priority over wr_ack in the same cycle.
//  Latency: start at cycle N -> busy=1, wr_req=1, wr_addr=0 with the first byte at N+1.
//  Byte generation, from the lfsr state L currently held (L is registered):
//   mode 01: L[7:0]; mode 10: L[7:0]&L[15:8]; mode 11: L[7:0]&L[15:8]&L[23:16].
//   mode 00: 8'h00; the LFSR still steps.
//  LFSR step (on each ack): L <= L[0] ? (L>>1)^LFSR_POLY : L>>1.
//   It never reaches 0 because of the seed substitution.
//  Handshake: wr_req stays high for the whole fill. On a cycle with wr_ack=1:
//   wr_addr+1, col/row advance, lfsr steps, new wr_data is registered, and wr_req stays high.
//   wr_ack while wr_req=0 is ignored. No combinational path from wr_ack to outputs.
//  Addressing: wr_addr = row*ROW_BYTES+col, held as an incrementing counter.
//   col wraps at ROW_BYTES-1 -> 0 with row+1.
//  Last byte: row=NUM_ROWS-1, col=ROW_BYTES-1 (addr 259199). On its ack:
//   wr_req=0, busy=0, done=1 in the next cycle.
//  Border (BORDER_DEAD=1): row 0 and row NUM_ROWS-1 -> 8'h00;
//   col 0 -> bit7 cleared; col ROW_BYTES-1 -> bit0 cleared.
//  Simultaneous start+abort in IDLE: abort wins, stay IDLE.
//  start while busy: ignored, with no restart.
//  Async reset mid-fill: immediate return to the reset state; a partial frame is left in SRAM.
// STRUCTURE
//  Shared package life_pkg: H_ACTIVE, V_ACTIVE, ROW_BYTES, FRAME_BYTES (259200),
//   density mode encodings, default LFSR_POLY.
//  One sub-module: life_lfsr32 (seed load with zero-substitution, step enable, state out).
//  The FSM, counters, border masking and density logic stay in life_seeder.
// TESTING
//  1 BORDER_DEAD=0, mode 01, seed 1, ack every cycle ->
//    addr0=8'h01, addr1=8'h03 (L=0x80200003 -> low byte 03).
//    259200 writes in total; done 1 cycle after the ack of addr 259199.
//  2 mode 00, seed 0 ->
//    every byte 8'h00 at addrs 0..259199.
//    A later start with seed 0 behaves exactly as seed 1.
//  3 BORDER_DEAD=1, mode 01 ->
//    addrs 0..239 and 258960..259199 are 8'h00.
//    addr 240 has bit7=0; addr 479 has bit0=0.
//  4 ack held low 10 cycles at addr 5 ->
//    wr_req, wr_addr=5 and wr_data are stable all 10 cycles; no lfsr step.
//  5 abort asserted together with the ack of addr 100 ->
//    next cycle wr_req=0, busy=0, done never pulses.
//    Stray acks are ignored; a new start restarts from addr 0.
//  6 start while busy at addr 50 -> ignored, fill continues at addr 51.
//    rst_n low at addr 70 -> all outputs 0 at once.

Source files
------------

// File: rtl/life_pkg.sv
// Shared constants and types for the life frame-buffer blocks.
// Frame geometry, density mode encodings and the default seeder LFSR polynomial.
package life_pkg;

  localparam int unsigned H_ACTIVE    = 1920;
  localparam int unsigned V_ACTIVE    = 1080;
  localparam int unsigned ROW_BYTES   = H_ACTIVE / 8;
  localparam int unsigned FRAME_BYTES = ROW_BYTES * V_ACTIVE;

  // x^32 + x^22 + x^2 + x + 1, Galois form
  localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h8020_0003;

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'b00,
    MODE_D50   = 2'b01,
    MODE_D25   = 2'b10,
    MODE_D12   = 2'b11
  } density_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } seeder_state_e;

  // ANDing independent random bytes halves the live-cell probability each time.
  function automatic logic [7:0] density_byte(input density_e m, input logic [31:0] l);
    logic [7:0] b;
    b = '0;
    case (m)
      MODE_D50: b = l[7:0];
      MODE_D25: b = l[7:0] & l[15:8];
      MODE_D12: b = l[7:0] & l[15:8] & l[23:16];
      default:  b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/life_seeder_if.sv
// Byte-write request port between the seeder and the SRAM controller.
interface life_seeder_if #(
  parameter int unsigned ADDR_WIDTH = 19
) ();
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic                  wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/life_lfsr32.sv
// 32-bit Galois LFSR with seed load (zero seed becomes 1) and step enable.
module life_lfsr32
  import life_pkg::*;
#(
  parameter logic [31:0] POLY = LFSR_POLY_DEFAULT
) (
  input  logic        clk_pixel,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state <= 32'd1;
    end else if (load) begin
      state <= (seed == '0) ? 32'd1 : seed;
    end else if (step) begin
      state <= state[0] ? ((state >> 1) ^ POLY) : (state >> 1);
    end
  end

endmodule

// File: rtl/life_seeder.sv
// Fills the life frame buffer with a random (or cleared) first generation
// through a req/ack byte-write port; one byte per acknowledged request.
module life_seeder
  import life_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 19,
  parameter int unsigned ROW_BYTES   = 240,
  parameter int unsigned NUM_ROWS    = 1080,
  parameter int unsigned BORDER_DEAD = 1,
  parameter logic [31:0] LFSR_POLY   = LFSR_POLY_DEFAULT
) (
  input  logic          clk_pixel,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [31:0]   seed,
  life_seeder_if.master wr,
  output logic          busy,
  output logic          done
);

  localparam int unsigned COL_W = $clog2(ROW_BYTES);
  localparam int unsigned ROW_W = $clog2(NUM_ROWS);

  seeder_state_e         state_q, state_d;
  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  density_e              mode_q;
  logic                  done_q;
  logic [31:0]           lfsr;
  logic                  load, step, finish;
  logic                  col_last, last_byte;
  logic [7:0]            byte_raw, byte_out;

  assign col_last  = (col_q == COL_W'(ROW_BYTES - 1));
  assign last_byte = col_last && (row_q == ROW_W'(NUM_ROWS - 1));

  life_lfsr32 #(.POLY(LFSR_POLY)) u_lfsr (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .load      (load),
    .seed      (seed),
    .step      (step),
    .state     (lfsr)
  );

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // abort outranks both start (in IDLE) and wr_ack (in FILL)
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_FILL;
          load    = 1'b1;
        end
      end
      ST_FILL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (wr.wr_ack) begin
          step = 1'b1;
          if (last_byte) begin
            state_d = ST_IDLE;
            finish  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
      mode_q <= MODE_CLEAR;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        col_q  <= '0;
        row_q  <= '0;
        addr_q <= '0;
        mode_q <= density_e'(mode);
      end else if (step) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  // Data is derived purely from registered state, so wr_ack never reaches an output.
  always_comb begin
    byte_raw = density_byte(mode_q, lfsr);
    byte_out = byte_raw;
    if (BORDER_DEAD != 0) begin
      if (row_q == '0 || row_q == ROW_W'(NUM_ROWS - 1)) byte_out = '0;
      if (col_q == '0) byte_out[7] = 1'b0;
      if (col_last)    byte_out[0] = 1'b0;
    end
  end

  assign wr.wr_req  = (state_q == ST_FILL);
  assign wr.wr_addr = addr_q;
  assign wr.wr_data = (state_q == ST_FILL) ? byte_out : '0;
  assign busy       = (state_q == ST_FILL);
  assign done       = done_q;

endmodule
